hilo_unit: RTL and testbench

- Consumer end of the ALU's 64-bit result path.
- Accepts ALU result packets (ALUControl plus ALUResult) through a valid/ready handshake and buffers them in a small in-order FIFO.
- Commits each packet to the architectural HI/LO registers: MULT/MULTU/DIV/DIVU write, MADD/MSUB accumulate, MTHI/MTLO move.
- Returns MFHI/MFLO read data through a valid/ready output port toward register-file writeback.

---
 rtl/hilo_unit.sv | 182 ++++++++++++++++++
 tb/tb_hilo_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Purpose:
//   Consumer end of the ALU 64-bit result path. ALU result packets
//   (operation code + 64-bit result) enter through a valid/ready handshake and
//   wait in a small in-order FIFO. The head packet commits to the
//   architectural HI/LO registers (write, accumulate or move). MFHI/MFLO reads
//   are returned through a valid/ready output port toward writeback.
//
// Parameters:
//   DEPTH       input FIFO entries (power of two, at least 2)
//
// Ports:
//   Clk         clock, all state updates on the rising edge
//   Rst_n       asynchronous active-low reset
//   InValid     packet on ALUControl/ALUResult is valid
//   InReady     unit can accept a packet this cycle
//   ALUControl  5-bit operation code (ALU encoding)
//   ALUResult   64-bit ALU output for this operation
//   RdValid     RdData holds an MFHI/MFLO result
//   RdReady     downstream accepts RdData this cycle
//   RdData      32-bit MFHI/MFLO read value
//   HI, LO      architectural HI/LO registers
//   Busy        FIFO non-empty or RdValid high
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  ALUControl,
  input  logic [63:0] ALUResult,
  output logic        RdValid,
  input  logic        RdReady,
  output logic [31:0] RdData,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b01001;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MADD  = 5'b10001;
  localparam logic [4:0] OP_MSUB  = 5'b10010;
  localparam logic [4:0] OP_MFHI  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MFLO  = 5'b10111;
  localparam logic [4:0] OP_MTLO  = 5'b11000;

  // 64-bit accumulate, wrapping modulo 2^64 (no overflow reporting).
  function automatic logic [63:0] acc64(input logic [63:0] acc,
                                        input logic [63:0] val,
                                        input logic        sub);
    acc64 = sub ? (acc - val) : (acc + val);
  endfunction

  // FIFO storage: data only, never reset; validity is tracked by count_q.
  logic [4:0]  ctrl_mem [DEPTH];
  logic [63:0] res_mem  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic        push;
  logic        pop;
  logic [4:0]  head_ctrl;
  logic [63:0] head_res;
  logic        head_is_mf;
  logic        slot_free;

  assign InReady    = (count_q < FULL_CNT);
  assign push       = InValid & InReady;

  assign head_ctrl  = ctrl_mem[rd_ptr_q];
  assign head_res   = res_mem[rd_ptr_q];
  assign head_is_mf = (head_ctrl == OP_MFHI) || (head_ctrl == OP_MFLO);

  // The output slot can take a new read if it is empty or draining now.
  assign slot_free  = !rd_valid_q || RdReady;

  // A read at the head stalls everything behind it until the slot frees,
  // keeping commits strictly in order.
  assign pop        = (count_q != '0) && (!head_is_mf || slot_free);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A completed transfer empties the slot; an MF* committing on the same
    // edge refills it below.
    if (rd_valid_q && RdReady) begin
      rd_valid_d = 1'b0;
    end

    if (pop) begin
      case (head_ctrl)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          hi_d = head_res[63:32];
          lo_d = head_res[31:0];
        end
        OP_MADD, OP_MSUB: begin
          {hi_d, lo_d} = acc64({hi_q, lo_q}, head_res, head_ctrl == OP_MSUB);
        end
        OP_MTHI: hi_d = head_res[31:0];
        OP_MTLO: lo_d = head_res[31:0];
        OP_MFHI: begin
          rd_data_d  = hi_q;
          rd_valid_d = 1'b1;
        end
        OP_MFLO: begin
          rd_data_d  = lo_q;
          rd_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      ctrl_mem[wr_ptr_q] <= ALUControl;
      res_mem[wr_ptr_q]  <= ALUResult;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
  assign Busy    = (count_q != '0) || rd_valid_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [4:0]  ALUControl;
  logic [63:0] ALUResult;
  logic        RdValid;
  logic        RdReady;
  logic [31:0] RdData;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b01001;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_DIVU  = 5'b10000;
  localparam logic [4:0] OP_MADD  = 5'b10001;
  localparam logic [4:0] OP_MSUB  = 5'b10010;
  localparam logic [4:0] OP_MFHI  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MFLO  = 5'b10111;
  localparam logic [4:0] OP_MTLO  = 5'b11000;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_NONE  = 5'b11111;

  hilo_unit #(.DEPTH(2)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .InValid    (InValid),
    .InReady    (InReady),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .RdValid    (RdValid),
    .RdReady    (RdReady),
    .RdData     (RdData),
    .HI         (HI),
    .LO         (LO),
    .Busy       (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [63:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one packet and hold it until accepted; returns 1ns after the
  // accepting edge with InValid dropped.
  task automatic push_one(input logic [4:0] ctrl, input logic [63:0] res);
    int n;
    @(negedge Clk);
    InValid    = 1'b1;
    ALUControl = ctrl;
    ALUResult  = res;
    n = 0;
    while (!InReady && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      chk("push_timeout", 64'(InReady), 64'd1);
    end
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  initial begin
    logic [31:0] lo_before;

    vecs[0]  = '{OP_MULT,  64'h00000001_FFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32'h0};
    vecs[1]  = '{OP_MULTU, 64'h0,                 32'h0,        32'h0,        1'b0, 32'h0};
    vecs[2]  = '{OP_MADD,  64'h10,                32'h0,        32'h10,       1'b0, 32'h0};
    vecs[3]  = '{OP_MADD,  64'h12,                32'h0,        32'h22,       1'b0, 32'h0};
    vecs[4]  = '{OP_MSUB,  64'h30,                32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 32'h0};
    vecs[5]  = '{OP_MTHI,  64'hDEAD0000_0FFF0000, 32'h0FFF0000, 32'hFFFFFFF2, 1'b0, 32'h0};
    vecs[6]  = '{OP_MFHI,  64'h0,                 32'h0FFF0000, 32'hFFFFFFF2, 1'b1, 32'h0FFF0000};
    vecs[7]  = '{OP_ADD,   64'h1234,              32'h0FFF0000, 32'hFFFFFFF2, 1'b0, 32'h0FFF0000};
    vecs[8]  = '{OP_MTLO,  64'h00000001_00000005, 32'h0FFF0000, 32'h5,        1'b0, 32'h0FFF0000};
    vecs[9]  = '{OP_MFLO,  64'h0,                 32'h0FFF0000, 32'h5,        1'b1, 32'h5};
    vecs[10] = '{OP_DIV,   64'hAAAAAAAA_55555555, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h5};
    vecs[11] = '{OP_DIVU,  64'h9,                 32'h0,        32'h9,        1'b0, 32'h5};
    vecs[12] = '{OP_MADD,  64'hFFFFFFFF_FFFFFFFF, 32'h0,        32'h8,        1'b0, 32'h5};
    vecs[13] = '{OP_MADD,  64'hFFFFFFF8,          32'h1,        32'h0,        1'b0, 32'h5};
    vecs[14] = '{OP_NONE,  64'h1,                 32'h1,        32'h0,        1'b0, 32'h5};
    vecs[15] = '{OP_MSUB,  64'h1,                 32'h0,        32'hFFFFFFFF, 1'b0, 32'h5};
    vecs[16] = '{OP_MULT,  64'h9,                 32'h0,        32'h9,        1'b0, 32'h5};

    Rst_n      = 1'b0;
    InValid    = 1'b0;
    ALUControl = '0;
    ALUResult  = '0;
    RdReady    = 1'b1;

    // Reset state
    #1;
    chk("rst_hi", 64'(HI), 64'h0);
    chk("rst_lo", 64'(LO), 64'h0);
    chk("rst_rdvalid", 64'(RdValid), 64'h0);
    chk("rst_rddata", 64'(RdData), 64'h0);
    chk("rst_inready", 64'(InReady), 64'h1);
    chk("rst_busy", 64'(Busy), 64'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("rel_inready", 64'(InReady), 64'h1);
    chk("rel_busy", 64'(Busy), 64'h0);

    // Single-packet table: each packet commits one edge after acceptance
    for (int i = 0; i < NV; i++) begin
      push_one(vecs[i].ctrl, vecs[i].res);
      chk($sformatf("v%0d_busy_acc", i), 64'(Busy), 64'h1);
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_hi", i), 64'(HI), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(LO), 64'(vecs[i].lo));
      chk($sformatf("v%0d_rdvalid", i), 64'(RdValid), 64'(vecs[i].rv));
      chk($sformatf("v%0d_rddata", i), 64'(RdData), 64'(vecs[i].rd));
      chk($sformatf("v%0d_busy", i), 64'(Busy), 64'(vecs[i].rv));
    end

    // Back-to-back MTHI then MFHI, RdReady high
    lo_before = LO;
    push_one(OP_MTHI, 64'h0FFF0000);
    push_one(OP_MFHI, 64'h0);
    chk("b2b_hi", 64'(HI), 64'h0FFF0000);
    chk("b2b_rv_early", 64'(RdValid), 64'h0);
    @(posedge Clk);
    #1;
    chk("b2b_rv", 64'(RdValid), 64'h1);
    chk("b2b_rd", 64'(RdData), 64'h0FFF0000);
    chk("b2b_lo", 64'(LO), 64'(lo_before));
    @(posedge Clk);
    #1;
    chk("b2b_rv_drop", 64'(RdValid), 64'h0);
    chk("b2b_busy", 64'(Busy), 64'h0);

    // Backpressure on the read port
    push_one(OP_MULT, 64'h9);
    @(negedge Clk);
    RdReady = 1'b0;
    push_one(OP_MFLO, 64'h0);
    push_one(OP_MFLO, 64'h0);
    chk("bp_rv1", 64'(RdValid), 64'h1);
    chk("bp_rd1", 64'(RdData), 64'h9);
    push_one(OP_MTLO, 64'h5);
    chk("bp_full", 64'(InReady), 64'h0);
    @(negedge Clk);
    InValid    = 1'b1;
    ALUControl = OP_MTHI;
    ALUResult  = 64'h7;
    repeat (3) @(posedge Clk);
    #1;
    chk("bp_held_ready", 64'(InReady), 64'h0);
    chk("bp_held_rd", 64'(RdData), 64'h9);
    chk("bp_held_lo", 64'(LO), 64'h9);
    chk("bp_held_hi", 64'(HI), 64'h0);
    @(negedge Clk);
    RdReady = 1'b1;
    @(posedge Clk);
    #1;
    chk("bp_rv2", 64'(RdValid), 64'h1);
    chk("bp_rd2", 64'(RdData), 64'h9);
    chk("bp_lo_pre", 64'(LO), 64'h9);
    chk("bp_ready_again", 64'(InReady), 64'h1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    chk("bp_lo5", 64'(LO), 64'h5);
    chk("bp_rv_drop", 64'(RdValid), 64'h0);
    @(posedge Clk);
    #1;
    chk("bp_hi7", 64'(HI), 64'h7);
    chk("bp_idle", 64'(Busy), 64'h0);

    // Reset mid-operation with a queued MADD and a pending read
    @(negedge Clk);
    RdReady = 1'b0;
    push_one(OP_MFHI, 64'h0);
    push_one(OP_MFHI, 64'h0);
    push_one(OP_MADD, 64'h8);
    chk("mr_full", 64'(InReady), 64'h0);
    chk("mr_rv", 64'(RdValid), 64'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("mr_hi", 64'(HI), 64'h0);
    chk("mr_lo", 64'(LO), 64'h0);
    chk("mr_rv0", 64'(RdValid), 64'h0);
    chk("mr_rd0", 64'(RdData), 64'h0);
    chk("mr_busy0", 64'(Busy), 64'h0);
    chk("mr_ready", 64'(InReady), 64'h1);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n   = 1'b1;
    RdReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("post_hi", 64'(HI), 64'h0);
    chk("post_lo", 64'(LO), 64'h0);
    chk("post_rv", 64'(RdValid), 64'h0);
    chk("post_busy", 64'(Busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
